// File: rtl/paddle_ctrl_n.sv
// Multi-paddle position controller: button or ball-tracking movement per paddle,
// with press acceleration, strobe-paced motion and clamping to the visible area.
module paddle_ctrl_n #(
    parameter int NUM_PADDLES = 2,
    parameter int Y_W         = 11,
    parameter int SCREEN_H    = 480,
    parameter int BAT_SMALL   = 48,
    parameter int BAT_LARGE   = 96,
    parameter int STEP_TICK   = 250000,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_STEPS = 8,
    parameter int AI_SPEED    = 2,
    parameter int AI_DEADBAND = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bat_size,
    input  logic [NUM_PADDLES-1:0]     up,
    input  logic [NUM_PADDLES-1:0]     down,
    input  logic [NUM_PADDLES-1:0]     ai_en,
    input  logic [Y_W-1:0]             ball_y,
    input  logic                       freeze,
    output logic [NUM_PADDLES*Y_W-1:0] pos_y,
    output logic [NUM_PADDLES-1:0]     moving
);

    localparam int TICK_W = $clog2(STEP_TICK);
    localparam int SPD_W  = $clog2(MAX_SPEED + 1);
    localparam int ACC_W  = $clog2(ACCEL_STEPS + 1);
    localparam logic [Y_W-1:0] RESET_POS = Y_W'((SCREEN_H - BAT_SMALL) / 2);

    typedef enum logic [1:0] {IDLE, MV_UP, MV_DN} state_t;

    logic [TICK_W-1:0] tick_q, tick_d;
    logic              strobe;
    logic [Y_W-1:0]    bat_h, limit;

    always_comb begin
        strobe = (tick_q == TICK_W'(STEP_TICK - 1));
        tick_d = strobe ? '0 : tick_q + 1'b1;
        bat_h  = bat_size ? Y_W'(BAT_LARGE) : Y_W'(BAT_SMALL);
        limit  = Y_W'(SCREEN_H) - bat_h;
    end

    // Free-running movement pacer; keeps running through freeze.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tick_q <= '0;
        else      tick_q <= tick_d;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PADDLES; gi++) begin : g_paddle
            state_t           state_q, state_d, target;
            logic [SPD_W-1:0] speed_q, speed_d;
            logic [ACC_W-1:0] accel_q, accel_d;
            logic [Y_W-1:0]   pos_q, pos_d;
            logic             moving_q, moving_d;
            logic             req_up, req_dn;
            logic [Y_W:0]     centre, ball_ext, step, sum;

            always_comb begin
                centre   = {1'b0, pos_q} + (Y_W+1)'(bat_h >> 1);
                ball_ext = {1'b0, ball_y};
                if (ai_en[gi]) begin
                    req_up = centre > ball_ext + (Y_W+1)'(AI_DEADBAND);
                    req_dn = centre + (Y_W+1)'(AI_DEADBAND) < ball_ext;
                end else begin
                    req_up = up[gi] & ~down[gi];
                    req_dn = down[gi] & ~up[gi];
                end

                state_d = state_q;
                speed_d = speed_q;
                accel_d = accel_q;
                pos_d   = pos_q;
                target  = req_up ? MV_UP : MV_DN;
                if (freeze || !(req_up || req_dn)) begin
                    state_d = IDLE;
                    speed_d = SPD_W'(1);
                    accel_d = '0;
                end else if (target != state_q) begin
                    state_d = target;
                    speed_d = SPD_W'(1);
                    accel_d = '0;
                end

                // The move uses the post-transition state and speed.
                step = ai_en[gi] ? (Y_W+1)'(AI_SPEED) : (Y_W+1)'(speed_d);
                sum  = {1'b0, pos_q} + step;
                if (strobe && !freeze && state_d != IDLE) begin
                    if (state_d == MV_UP)
                        pos_d = ({1'b0, pos_q} >= step) ? pos_q - step[Y_W-1:0] : '0;
                    else
                        pos_d = (sum <= {1'b0, limit}) ? sum[Y_W-1:0] : limit;
                    if (!ai_en[gi]) begin
                        if (accel_d == ACC_W'(ACCEL_STEPS - 1)) begin
                            accel_d = '0;
                            if (speed_d < SPD_W'(MAX_SPEED)) speed_d = speed_d + 1'b1;
                        end else begin
                            accel_d = accel_d + 1'b1;
                        end
                    end
                end

                // Bat growth near the bottom pulls the paddle back on screen, even frozen.
                if (pos_q > limit) pos_d = limit;
                moving_d = (state_d != IDLE);
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q  <= IDLE;
                    speed_q  <= SPD_W'(1);
                    accel_q  <= '0;
                    pos_q    <= RESET_POS;
                    moving_q <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    speed_q  <= speed_d;
                    accel_q  <= accel_d;
                    pos_q    <= pos_d;
                    moving_q <= moving_d;
                end
            end

            assign pos_y[gi*Y_W +: Y_W] = pos_q;
            assign moving[gi]           = moving_q;
        end
    endgenerate

endmodule

// File: tb/tb_paddle_ctrl_n.sv
// Scoreboard bench for paddle_ctrl_n: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_paddle_ctrl_n;
    localparam int NP  = 3;
    localparam int YW  = 11;
    localparam int TCK = 4;

    logic            clk, rst, bat_size, freeze;
    logic [NP-1:0]   up, down, ai_en, moving;
    logic [YW-1:0]   ball_y;
    logic [NP*YW-1:0] pos_y;

    paddle_ctrl_n #(.NUM_PADDLES(NP), .Y_W(YW), .STEP_TICK(TCK)) dut (
        .clk(clk), .rst(rst), .bat_size(bat_size), .up(up), .down(down),
        .ai_en(ai_en), .ball_y(ball_y), .freeze(freeze), .pos_y(pos_y), .moving(moving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    kind;
        int    idx;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   act;
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = (e.kind == 0) ? int'(pos_y[e.idx*YW +: YW]) : int'(moving[e.idx]);
            checks++;
            if (act != e.val) begin
                errors++;
                $display("FAIL %s: actual %0d required %0d", e.name, act, e.val);
            end else begin
                $display("ok   %s: %0d", e.name, act);
            end
        end
    end

    task automatic exp_pos(input string name, input int idx, input int val);
        sb_q.push_back('{name, 0, idx, val});
    endtask

    task automatic exp_mov(input string name, input int idx, input int val);
        sb_q.push_back('{name, 1, idx, val});
    endtask

    // Returns 1 time unit after the n-th posedge on which the DUT strobes.
    task automatic wait_strobes(input int n);
        for (int k = 0; k < n; k++) begin
            do @(posedge clk); while ((cyc % TCK) != TCK - 1);
        end
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; bat_size = 1'b0; freeze = 1'b0;
        up = '0; down = '0; ai_en = '0; ball_y = '0;
        #12;
        for (int i = 0; i < NP; i++) begin
            exp_pos($sformatf("rst_pos%0d", i), i, 216);
            exp_mov($sformatf("rst_mov%0d", i), i, 0);
        end
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        exp_pos("rel_pos0", 0, 216);
        exp_mov("rel_mov0", 0, 0);

        // Accelerating climb to the top edge.
        up[0] = 1'b1;
        wait_strobes(8);  exp_pos("up_s8", 0, 208); exp_mov("up_mov", 0, 1);
        wait_strobes(8);  exp_pos("up_s16", 0, 192);
        wait_strobes(8);  exp_pos("up_s24", 0, 168);
        wait_strobes(8);  exp_pos("up_s32", 0, 136);
        wait_strobes(34); exp_pos("up_s66", 0, 0);
        wait_strobes(4);  exp_pos("up_nowrap", 0, 0);
        exp_pos("up_p1_still", 1, 216); exp_pos("up_p2_still", 2, 216);
        up[0] = 1'b0;
        @(posedge clk); #1 exp_mov("up_rel_mov", 0, 0);

        // Saturate at the bottom, then grow the bat while frozen.
        down[1] = 1'b1;
        wait_strobes(70); exp_pos("dn_sat", 1, 432);
        freeze = 1'b1; bat_size = 1'b1;
        exp_pos("clamp_before", 1, 432);
        @(posedge clk); #1;
        exp_pos("clamp_after", 1, 384);
        exp_mov("frz_mov1", 1, 0);
        freeze = 1'b0; down[1] = 1'b0; bat_size = 1'b0;

        // Conflicting buttons, then release one.
        up[2] = 1'b1; down[2] = 1'b1;
        wait_strobes(3); exp_pos("both_pos", 2, 216); exp_mov("both_mov", 2, 0);
        down[2] = 1'b0;
        wait_strobes(1); exp_pos("rel_s1", 2, 215);
        wait_strobes(7); exp_pos("rel_s8", 2, 208);
        wait_strobes(1); exp_pos("rel_s9", 2, 206);
        up[2] = 1'b0;

        // Freeze holds position; motion resumes at speed 1.
        freeze = 1'b1; down[0] = 1'b1;
        wait_strobes(10); exp_pos("frz_pos", 0, 0); exp_mov("frz_mov0", 0, 0);
        freeze = 1'b0;
        wait_strobes(1); exp_pos("unfrz_s1", 0, 1); exp_mov("unfrz_mov", 0, 1);
        wait_strobes(7); exp_pos("unfrz_s8", 0, 8);
        wait_strobes(1); exp_pos("unfrz_s9", 0, 10);

        // Ball tracking; buttons on paddle 0 are ignored.
        ai_en[0] = 1'b1; ball_y = 11'd400; bat_size = 1'b1;
        wait_strobes(2); exp_pos("ai_s2", 0, 14);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        exp_pos("async_rst_pos0", 0, 216);
        exp_mov("async_rst_mov0", 0, 0);
        exp_pos("async_rst_pos1", 1, 216);
        @(negedge clk); #2 rst = 1'b1;
        up[0] = 1'b1;
        wait_strobes(10); exp_pos("ai_s10", 0, 236); exp_mov("ai_mov", 0, 1);
        wait_strobes(56); exp_pos("ai_s66", 0, 348);
        wait_strobes(4);  exp_pos("ai_settled", 0, 348); exp_mov("ai_idle", 0, 0);
        ai_en = '0; up = '0; down = '0;

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
